// File: rtl/div_ctrl.sv
// Issue/complete controller for RV64M divides: latches operands for the iterative core,
// resolves divide-by-zero and signed overflow locally, and returns one result pulse.
module div_ctrl #(
   parameter int XLEN = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [1:0]        in_op,
   input  logic              in_word,
   input  logic [XLEN-1:0]   in_a,
   input  logic [XLEN-1:0]   in_b,
   input  logic              flush,
   output logic              stall,
   output logic              out_valid,
   output logic [XLEN-1:0]   out_result,
   output logic              dv_valid,
   output logic [XLEN-1:0]   dv_a,
   output logic [XLEN-1:0]   dv_b,
   output logic              dv_s,
   output logic              dv_w,
   input  logic              dv_done,
   input  logic [2*XLEN-1:0] dv_c
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   state_t state_q;
   state_t state_d;

   logic            is_rem_q;
   logic            load_ops;
   logic            load_special;
   logic            load_core;

   logic [XLEN-1:0] a_width;
   logic            b_zero;
   logic            a_min_neg;
   logic            b_neg_one;
   logic            overflow;
   logic            special;
   logic [XLEN-1:0] special_result;

   logic [XLEN-1:0] core_sel;
   logic [XLEN-1:0] core_result;

   // W variants compare only the low word; the dividend is seen sign-extended from bit 31.
   always_comb begin
      a_width   = in_word ? {{(XLEN-32){in_a[31]}}, in_a[31:0]} : in_a;
      b_zero    = in_word ? (in_b[31:0] == 32'd0) : (in_b == '0);
      a_min_neg = in_word ? (in_a[31:0] == 32'h8000_0000)
                          : (in_a == {1'b1, {(XLEN-1){1'b0}}});
      b_neg_one = in_word ? (in_b[31:0] == 32'hFFFF_FFFF) : (in_b == '1);
      overflow  = ~in_op[0] & a_min_neg & b_neg_one;
      special   = b_zero | overflow;
      if (in_op[1]) begin
         special_result = b_zero ? a_width : '0;
      end else begin
         special_result = b_zero ? '1 : a_width;
      end
   end

   // The core's upper word is don't-care for W operations, so it is replaced by sign extension.
   always_comb begin
      core_sel    = is_rem_q ? dv_c[2*XLEN-1:XLEN] : dv_c[XLEN-1:0];
      core_result = dv_w ? {{(XLEN-32){core_sel[31]}}, core_sel[31:0]} : core_sel;
   end

   // Next-state and handshake decode; flush overrides any accept or completion.
   always_comb begin
      state_d      = state_q;
      load_ops     = 1'b0;
      load_special = 1'b0;
      load_core    = 1'b0;
      stall        = 1'b0;
      dv_valid     = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid && !flush) begin
               stall    = 1'b1;
               load_ops = 1'b1;
               if (special) begin
                  load_special = 1'b1;
                  state_d      = RESP;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            stall    = 1'b1;
            dv_valid = 1'b1;
            if (dv_done && !flush) begin
               load_core = 1'b1;
               state_d   = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (flush) begin
         state_d = IDLE;
      end
   end

   // State, operand and result registers; reset and flush both return everything to zero.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         state_q    <= IDLE;
         is_rem_q   <= 1'b0;
         out_valid  <= 1'b0;
         out_result <= '0;
         dv_a       <= '0;
         dv_b       <= '0;
         dv_s       <= 1'b0;
         dv_w       <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_valid <= load_special | load_core;
         if (load_ops) begin
            dv_a     <= in_a;
            dv_b     <= in_b;
            dv_s     <= ~in_op[0];
            dv_w     <= in_word;
            is_rem_q <= in_op[1];
         end
         if (load_special) begin
            out_result <= special_result;
         end else if (load_core) begin
            out_result <= core_result;
         end
      end
   end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Issue/complete controller for RV64M divide instructions (DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW). Sits in the execute stage between the decode/execute pipeline registers and the iterative divider core. It performs four tasks:
- latches the operands and holds the core's request stable until the core finishes;
- resolves RISC-V divide-by-zero and signed-overflow cases itself, without starting the core;
- selects quotient or remainder and sign-extends W results;
- stalls the pipeline until it returns one result pulse.

## Interface
Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  execute stage presents a divide instruction.
- in_op  in  2  {is_rem, is_unsigned}: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- in_word  in  1  W variant (32-bit operation, 64-bit sign-extended result).
- in_a, in_b  in  64  dividend, divisor.
- flush  in  1  abort the current operation (redirect/exception).
- stall  out  1  hold the pipeline.
- out_valid  out  1  one-cycle result strobe.
- out_result  out  64  final rd value.
- dv_valid  out  1  request to the divider core.
- dv_a, dv_b  out  64  registered operands to the core.
- dv_s  out  1  signed operation (core s).
- dv_w  out  1  32-bit operation (core w).
- dv_done  in  1  core completion pulse.
- dv_c  in  128  core result {remainder, quotient}; combinational in the core, valid while dv_done=1.

## Operation
States: IDLE, BUSY, RESP.

Reset, or flush in any state:
- next state IDLE.
- Registered outputs clear: out_valid=0, out_result=0, dv_a=dv_b=0, dv_s=dv_w=0.
- Combinational outputs read 0 in IDLE: dv_valid=0, stall=0 when in_valid=0.
- flush has priority over in_valid and dv_done.

IDLE, in_valid=1 and flush=0 (accept):
- Latch in_a→dv_a, in_b→dv_b, ~in_op[0]→dv_s, in_word→dv_w, in_op[1]→is_rem.
- Evaluate the special cases on the effective width (low 32 bits when in_word=1):
  - Divide by zero (b==0): quotient = all ones; remainder = a (sext(a[31:0]) for W).
  - Signed overflow (dv_s=1, a==most-negative, b==-1): quotient = a (W: 64'hFFFF_FFFF_8000_0000); remainder = 0.
  - A special case loads out_result directly and goes to RESP.
- Otherwise go to BUSY.

BUSY:
- dv_valid=1 and operands held constant.
- When dv_done=1: pick the half by is_rem (quotient dv_c[63:0], remainder dv_c[127:64]).
- If dv_w, replace the selection with sext(selection[31:0]), ignoring the core's upper bits.
- Register the result into out_result and go to RESP.

RESP:
- out_valid=1 for exactly one cycle, stall=0, then IDLE.
- in_valid during RESP belongs to the completing instruction and is ignored (no re-accept).

Other rules:
- stall = (IDLE & in_valid & ~flush) | BUSY. It is combinational, so it is high in the accept cycle.
- dv_valid = BUSY, decoded from state. It drops the cycle after dv_done is sampled, or on flush; a low dv_valid returns the core to idle.
- dv_done outside BUSY is ignored.
- out_result holds its last value after RESP until the next result load.

## Timing
- Special case: out_valid 1 cycle after accept (accept at cycle N, out_valid at N+1). The core never sees dv_valid.
- Normal case: out_valid is the cycle after the one where dv_done=1 is sampled in BUSY. Latency is data-independent and set by the core; with the current 64-iteration core it is approximately 69 cycles.
  - The bench must not hard-code latency.
  - Exactly one out_valid per accepted, unflushed instruction.
- Back-to-back: a new accept is possible the cycle after RESP, since IDLE is re-entered.
- Operands on in_a/in_b may change after the accept cycle without effect.
- Flush during BUSY: dv_valid=0 next cycle and no out_valid. A later dv_done from the aborted operation is ignored.

## Test plan
- DIV a=7, b=-2 (0xFFFF_FFFF_FFFF_FFFE) -> stall high until RESP; out_result=0xFFFF_FFFF_FFFF_FFFD, single out_valid pulse.
- REMW a=0x0000_0000_8000_0007, b=2 -> out_result=0xFFFF_FFFF_FFFF_FFFF (-1); DIVUW same operands -> 0x0000_0000_4000_0003.
- DIVU/REM by zero, a=0x1234 -> DIVU 0xFFFF_FFFF_FFFF_FFFF, REM 0x1234; out_valid one cycle after accept, dv_valid never asserted.
- DIV a=0x8000_0000_0000_0000, b=-1 -> quotient 0x8000_0000_0000_0000; REM -> 0; DIVW a=0x8000_0000, b=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000. No core request in any of these.
- Flush 10 cycles into BUSY -> IDLE next cycle, dv_valid=0, no out_valid; then a new DIVU 100/7 -> 14.
- Reset asserted mid-BUSY -> all outputs 0 next cycle; two back-to-back REMU (100%7=2, 9%4=1) -> two separate out_valid pulses with correct values.
